// File: rtl/pulse_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int pend_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_if.sv
// Request/output bundle of the pulse stretcher.
interface pulse_if #(
  parameter int PEND_W = 2
);
  logic              din;
  logic              dout;
  logic              busy;
  logic              ovf;
  logic [PEND_W-1:0] pend;

  modport master (
    output din,
    input  dout, busy, pend, ovf
  );

  modport slave (
    input  din,
    output dout, busy, pend, ovf
  );
endinterface

// File: rtl/sat_counter.sv
// Up/down counter that saturates at both ends.
import pulse_pkg::*;

module sat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         sat
);

  assign sat = (cnt == W'(pend_max(W)));

  always_comb begin
    nxt = cnt;
    if (inc && !dec && !sat)
      nxt = cnt + W'(1);
    else if (dec && !inc && cnt != '0)
      nxt = cnt - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= nxt;
  end

endmodule

// File: rtl/pulse_stretch.sv
// Stretches din pulses into WIDTH-cycle bursts spaced by GAP low cycles.
// Define PULSE_STRETCH_RETRIGGER_EN to let din during a burst extend it.
import pulse_pkg::*;

module pulse_stretch #(
  parameter int WIDTH  = 4,
  parameter int GAP    = 2,
  parameter int PEND_W = 2
) (
  input logic   clk,
  input logic   reset,
  pulse_if.slave io
);

  localparam int CW = cnt_width(WIDTH, GAP);
  localparam logic [CW-1:0] W1 = CW'(WIDTH - 1);
  localparam logic [CW-1:0] G1 = CW'(GAP - 1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [PEND_W-1:0] pend, pend_n;
  logic              take, dec, inc, sat, drop;
  logic              dout_q, busy_q, ovf_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    dec     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (io.din) begin
          state_n = ST_HIGH;
          cnt_n   = W1;
          take    = 1'b1;
        end
      end
      ST_HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (io.din) begin
          cnt_n = W1;
          take  = 1'b1;
        end else
`endif
        if (cnt == '0) begin
          state_n = ST_GAP;
          cnt_n   = G1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (pend != '0) begin
          state_n = ST_HIGH;
          cnt_n   = W1;
          dec     = 1'b1;
        end else if (io.din) begin
          state_n = ST_HIGH;
          cnt_n   = W1;
          take    = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // a request not launched this edge is queued, or dropped when full
  assign inc  = io.din && !take;
  assign drop = inc && sat && !dec;

  sat_counter #(.W(PEND_W)) u_pend (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .cnt   (pend),
    .nxt   (pend_n),
    .sat   (sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dout_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dout_q <= (state_n == ST_HIGH);
      busy_q <= (state_n != ST_IDLE) || (pend_n != '0);
      ovf_q  <= ovf_q | drop;
    end
  end

  assign io.dout = dout_q;
  assign io.busy = busy_q;
  assign io.ovf  = ovf_q;
  assign io.pend = pend;

endmodule

// File: tb/tb_pulse_stretch.sv
// Randomized and directed check of pulse_stretch against a schedule model.
module tb_pulse_stretch;
  import pulse_pkg::*;

  localparam int WIDTH  = 4;
  localparam int GAP    = 2;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  pulse_if #(.PEND_W(PEND_W)) io ();

  pulse_stretch #(
    .WIDTH  (WIDTH),
    .GAP    (GAP),
    .PEND_W (PEND_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: a burst occupies cycles [start, last_hi]; the next may start
  // no earlier than last_hi+GAP+1; q counts requests waiting for a slot.
  int cyc     = 0;
  int last_hi = -100;
  int q       = 0;
  bit movf    = 1'b0;

  always @(posedge clk or posedge reset) begin
    int  t;
    int  slot;
    bit  d;
    bit  used;
    if (reset) begin
      last_hi = -100;
      q       = 0;
      movf    = 1'b0;
    end else begin
      t    = cyc;
      d    = io.din;
      used = 1'b0;
      slot = last_hi + GAP + 1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
      if (d && t <= last_hi) begin
        last_hi = t + WIDTH;
        used    = 1'b1;
      end
`endif
      if (q > 0 && t + 1 == slot) begin
        q--;
        last_hi = t + WIDTH;
      end else if (d && !used && t + 1 >= slot) begin
        last_hi = t + WIDTH;
        used    = 1'b1;
      end
      if (d && !used) begin
        if (q < PMAX) q++;
        else          movf = 1'b1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    chk("dout", 32'(io.dout), 32'(cyc <= last_hi));
    chk("busy", 32'(io.busy), 32'((cyc <= last_hi + GAP) || q > 0));
    chk("pend", 32'(io.pend), 32'(q));
    chk("ovf",  32'(io.ovf),  32'(movf));
  end

  task automatic run(input logic [31:0] pat, input int n,
                     output logic [31:0] dv, output logic [31:0] bv,
                     output logic [31:0] p1, output logic [31:0] ov,
                     output int pmx);
    dv  = '0;
    bv  = '0;
    p1  = '0;
    ov  = '0;
    pmx = 0;
    for (int k = 0; k < n; k++) begin
      io.din = pat[k];
      @(negedge clk);
      dv[k] = io.dout;
      bv[k] = io.busy;
      p1[k] = (io.pend == 2'd1);
      ov[k] = io.ovf;
      if (int'(io.pend) > pmx) pmx = int'(io.pend);
      @(posedge clk);
      #1;
    end
    io.din = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [31:0] dv, bv, p1, ov;
  int          pmx;
  int          dens;

  initial begin
    reset  = 1'b1;
    io.din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(io.dout), 0);
    chk("rst_busy", 32'(io.busy), 0);
    chk("rst_pend", 32'(io.pend), 0);
    chk("rst_ovf",  32'(io.ovf),  0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run(32'h1, 10, dv, bv, p1, ov, pmx);
    chk("s1_dout", dv, 32'h1E);
    chk("s1_busy", bv, 32'h7E);
    chk("s1_pmax", 32'(pmx), 0);

    do_reset();
    run(32'h3, 12, dv, bv, p1, ov, pmx);
    chk("s2_dout",  dv, 32'h79E);
    chk("s2_pend1", p1, 32'h7C);

    do_reset();
    run(32'h1F, 26, dv, bv, p1, ov, pmx);
    chk("s3_dout", dv, 32'h79E79E);
    chk("s3_pmax", 32'(pmx), 3);
    chk("s3_ovf",  ov, 32'h3FFFFE0);

    do_reset();
    run(32'h41, 12, dv, bv, p1, ov, pmx);
    chk("s4_dout", dv, 32'h79E);
    chk("s4_pmax", 32'(pmx), 0);

    do_reset();
    run(32'h5, 12, dv, bv, p1, ov, pmx);
`ifdef PULSE_STRETCH_RETRIGGER_EN
    chk("s6_dout", dv, 32'h7E);
`else
    chk("s6_dout", dv, 32'h79E);
`endif

    do_reset();
    run(32'h7, 3, dv, bv, p1, ov, pmx);
`ifndef PULSE_STRETCH_RETRIGGER_EN
    chk("s5_pend_pre", 32'(io.pend), 2);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk("s5_dout", 32'(io.dout), 0);
    chk("s5_pend", 32'(io.pend), 0);
    chk("s5_busy", 32'(io.busy), 0);
    chk("s5_ovf",  32'(io.ovf),  0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(32'h0, 15, dv, bv, p1, ov, pmx);
    chk("s5_after_dout", dv, 0);
    chk("s5_after_busy", bv, 0);

    for (int ph = 0; ph < 12; ph++) begin
      dens = $urandom_range(5, 90);
      for (int k = 0; k < 200; k++) begin
        io.din = ($urandom_range(0, 99) < dens);
        @(posedge clk);
        #1;
      end
      if (ph == 6) begin
        io.din = 1'b0;
        #3;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
      end
    end
    io.din = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
